// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared widths and payload types for the register-file writeback path.
package reg_writeback_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 2;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

    typedef struct packed {
        reg_idx_t rd;
        xword_t   data;
    } ld_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Execute/LSU/decode side signals of the writeback controller.
interface reg_writeback_ctrl_if;
    import reg_writeback_ctrl_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_rd;
    xword_t   alu_data;
    logic     iss_valid;
    reg_idx_t iss_rd;
    logic     iss_ready;
    logic     ld_valid;
    reg_idx_t ld_rd;
    xword_t   ld_data;
    logic     ld_ready;
    reg_idx_t q_rs1;
    reg_idx_t q_rs2;
    reg_idx_t q_rd;
    logic     rs1_busy;
    logic     rs2_busy;
    logic     rd_busy;
    logic     wb_en;
    reg_idx_t wb_rd;
    xword_t   wb_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output iss_valid, iss_rd,
        output ld_valid, ld_rd, ld_data,
        output q_rs1, q_rs2, q_rd,
        input  iss_ready, ld_ready,
        input  rs1_busy, rs2_busy, rd_busy,
        input  wb_en, wb_rd, wb_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  iss_valid, iss_rd,
        input  ld_valid, ld_rd, ld_data,
        input  q_rs1, q_rs2, q_rd,
        output iss_ready, ld_ready,
        output rs1_busy, rs2_busy, rd_busy,
        output wb_en, wb_rd, wb_data
    );

endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Load-return FIFO: in-order buffer of {rd, data}, flushed by synchronous reset.
module wb_fifo
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_P = DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  ld_entry_t i_data,
    input  logic      i_pop,
    output ld_entry_t o_head_c,
    output logic      o_full_c,
    output logic      o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH_P);
    localparam int unsigned CW = AW + 1;

    ld_entry_t      r_mem [DEPTH_P];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full_c  = (r_count == CW'(DEPTH_P));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write port arbiter (ALU over buffered loads) with an outstanding-load scoreboard.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    reg_writeback_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ld_entry_t           w_head;
    ld_entry_t           w_ld_in;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [NREGS-1:0]    w_inc;
    logic [NREGS-1:0]    w_dec;

    logic                r_wb_en;
    logic                r_wb_is_load;
    reg_idx_t            r_wb_rd;
    xword_t              r_wb_data;
    logic [CNT_W-1:0]    r_cnt [NREGS];

    assign w_ld_in = '{rd: bus.ld_rd, data: bus.ld_data};
    assign w_push  = bus.ld_valid && !w_full;
    assign w_pop   = !bus.alu_valid && !w_empty;

    wb_fifo #(.DEPTH_P(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    (w_ld_in),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // ALU wins outright; a load is only written in a cycle with no ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en      <= 1'b0;
            r_wb_is_load <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else if (bus.alu_valid) begin
            r_wb_en      <= (bus.alu_rd != '0);
            r_wb_is_load <= 1'b0;
            r_wb_rd      <= bus.alu_rd;
            r_wb_data    <= bus.alu_data;
        end else if (w_pop) begin
            r_wb_en      <= (w_head.rd != '0);
            r_wb_is_load <= 1'b1;
            r_wb_rd      <= w_head.rd;
            r_wb_data    <= w_head.data;
        end else begin
            r_wb_en      <= 1'b0;
            r_wb_is_load <= 1'b0;
        end
    end

    // Decode masks bit 0 so x0's counter never leaves zero.
    assign w_inc = (bus.iss_valid && bus.iss_rd != '0)
                 ? (NREGS'(1) << bus.iss_rd) : '0;
    assign w_dec = (r_wb_en && r_wb_is_load && r_wb_rd != '0)
                 ? (NREGS'(1) << r_wb_rd) : '0;

    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (rst) begin
                r_cnt[r] <= '0;
            end else if (w_inc[r] && !w_dec[r] && r_cnt[r] != CNT_MAX) begin
                r_cnt[r] <= r_cnt[r] + CNT_W'(1);
            end else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0) begin
                r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end
        end
    end

    assign bus.ld_ready  = !w_full;
    assign bus.iss_ready = (r_cnt[bus.iss_rd] != CNT_MAX);
    assign bus.rs1_busy  = (r_cnt[bus.q_rs1] != '0);
    assign bus.rs2_busy  = (r_cnt[bus.q_rs2] != '0);
    assign bus.rd_busy   = (r_cnt[bus.q_rd] != '0);
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: vector table, directed corner sequences, random run vs queue model.
module tb_reg_writeback_ctrl;
    import reg_writeback_ctrl_pkg::*;

    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_writeback_ctrl_if bus ();

    reg_writeback_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: load queue, per-register pending counts, expected write port.
    ld_entry_t mq[$];
    int        mcnt [NREGS];
    logic      m_en, m_load, m_acc;
    reg_idx_t  m_rd;
    xword_t    m_data;

    typedef struct {
        logic     av;
        reg_idx_t rd;
        xword_t   d;
        logic     exp_en;
        reg_idx_t exp_rd;
        xword_t   exp_d;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < NREGS; r++) mcnt[r] = 0;
        m_en = 1'b0; m_load = 1'b0; m_rd = '0; m_data = '0; m_acc = 1'b0;
    endtask

    // One clock: check combinational outputs, take the edge, advance the model, check wb_*.
    task automatic cycle();
        logic      av, iv, lv, r;
        reg_idx_t  ar, ir, lr, inc_r, dec_r;
        xword_t    ad, ldd;
        ld_entry_t e;
        int        qsz;
        #1;
        chk("ld_ready", bus.ld_ready, 64'(mq.size() < DEPTH));
        chk("iss_ready", bus.iss_ready, 64'(mcnt[bus.iss_rd] < CMAX));
        chk("rs1_busy", bus.rs1_busy, 64'(bus.q_rs1 != 0 && mcnt[bus.q_rs1] != 0));
        chk("rs2_busy", bus.rs2_busy, 64'(bus.q_rs2 != 0 && mcnt[bus.q_rs2] != 0));
        chk("rd_busy",  bus.rd_busy,  64'(bus.q_rd  != 0 && mcnt[bus.q_rd]  != 0));
        av = bus.alu_valid; ar = bus.alu_rd; ad = bus.alu_data;
        iv = bus.iss_valid; ir = bus.iss_rd;
        lv = bus.ld_valid;  lr = bus.ld_rd;  ldd = bus.ld_data;
        r  = rst;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            dec_r = (m_en && m_load) ? m_rd : '0;
            inc_r = iv ? ir : '0;
            qsz   = mq.size();
            m_acc = lv && (qsz < DEPTH);
            if (av) begin
                m_en = (ar != 0); m_load = 1'b0; m_rd = ar; m_data = ad;
            end else if (qsz > 0) begin
                e = mq.pop_front();
                m_en = (e.rd != 0); m_load = 1'b1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_en = 1'b0; m_load = 1'b0;
            end
            if (m_acc) mq.push_back('{rd: lr, data: ldd});
            if (inc_r != 0 && inc_r != dec_r && mcnt[inc_r] < CMAX) mcnt[inc_r]++;
            if (dec_r != 0 && dec_r != inc_r && mcnt[dec_r] > 0)    mcnt[dec_r]--;
        end
        #1;
        chk("wb_en", bus.wb_en, 64'(m_en));
        if (m_en) begin
            chk("wb_rd", bus.wb_rd, 64'(m_rd));
            chk("wb_data", bus.wb_data, 64'(m_data));
        end
    endtask

    initial begin
        model_reset();
        idle();
        bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_wb_en", bus.wb_en, 64'(0));
        chk("rst_wb_rd", bus.wb_rd, 64'(0));
        chk("rst_wb_data", bus.wb_data, 64'(0));
        chk("rst_ld_ready", bus.ld_ready, 64'(1));
        chk("rst_iss_ready", bus.iss_ready, 64'(1));

        // Single-cycle ALU vectors from an empty FIFO.
        tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd31, 32'h0000_0001};
        tbl[2] = '{1'b1, 5'd0,  32'h1111_1111, 1'b0, 5'd0,  32'h0};
        tbl[3] = '{1'b0, 5'd7,  32'h2222_2222, 1'b0, 5'd0,  32'h0};
        tbl[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
        tbl[5] = '{1'b1, 5'd16, 32'hFFFF_FFFF, 1'b1, 5'd16, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = tbl[i].av; bus.alu_rd = tbl[i].rd; bus.alu_data = tbl[i].d;
            cycle();
            chk("vec_en", bus.wb_en, 64'(tbl[i].exp_en));
            if (tbl[i].exp_en) begin
                chk("vec_rd", bus.wb_rd, 64'(tbl[i].exp_rd));
                chk("vec_data", bus.wb_data, 64'(tbl[i].exp_d));
            end
        end
        idle();
        cycle();

        // Issue x7, load returns 3 cycles later; busy until the write has landed.
        bus.q_rd = 5'd7; bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        cycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("s2_busy_wait", bus.rd_busy, 64'(1));
        end
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234;
        cycle();
        chk("s2_no_bypass", bus.wb_en, 64'(0));
        idle();
        cycle();
        chk("s2_wb_en", bus.wb_en, 64'(1));
        chk("s2_wb_rd", bus.wb_rd, 64'(7));
        chk("s2_wb_data", bus.wb_data, 64'(32'h1234));
        chk("s2_busy_during_wb", bus.rd_busy, 64'(1));
        cycle();
        chk("s2_busy_after", bus.rd_busy, 64'(0));

        // Load to x9 behind 5 ALU cycles, then 4 back-to-back loads x1..x4.
        for (int k = 0; k < 5; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = reg_idx_t'(10 + k); bus.alu_data = xword_t'(k);
            bus.ld_valid = (k == 0); bus.ld_rd = 5'd9; bus.ld_data = 32'h9999;
            cycle();
            chk("s3_alu_rd", bus.wb_rd, 64'(10 + k));
        end
        idle();
        cycle();
        chk("s3_ld9_rd", bus.wb_rd, 64'(9));
        chk("s3_ld9_data", bus.wb_data, 64'(32'h9999));
        for (int k = 1; k <= 4; k++) begin
            bus.ld_valid = 1'b1; bus.ld_rd = reg_idx_t'(k); bus.ld_data = xword_t'(32'h100 + k);
            cycle();
            if (k >= 2) chk("s3_order", bus.wb_rd, 64'(k - 1));
        end
        idle();
        cycle();
        chk("s3_order_last", bus.wb_rd, 64'(4));
        cycle();

        // Fill the FIFO under continuous ALU traffic; 5th load is held then accepted.
        for (int k = 1; k <= 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = xword_t'(k);
            bus.ld_valid = 1'b1; bus.ld_rd = reg_idx_t'(k); bus.ld_data = xword_t'(32'h100 + k);
            cycle();
        end
        chk("s4_full", bus.ld_ready, 64'(0));
        bus.ld_rd = 5'd5; bus.ld_data = 32'h105;
        cycle();
        chk("s4_still_full", bus.ld_ready, 64'(0));
        bus.alu_valid = 1'b0;
        cycle();
        chk("s4_drain1", bus.wb_rd, 64'(1));
        chk("s4_ready_again", bus.ld_ready, 64'(1));
        cycle();
        chk("s4_drain2", bus.wb_rd, 64'(2));
        idle();
        for (int k = 3; k <= 5; k++) begin
            cycle();
            chk("s4_drain_rd", bus.wb_rd, 64'(k));
            chk("s4_drain_data", bus.wb_data, 64'(32'h100 + k));
        end
        cycle();

        // x0 handling and counter saturation on x3.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hABCD;
        cycle();
        idle();
        cycle();
        chk("s5_ld_x0", bus.wb_en, 64'(0));
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.q_rs1 = 5'd0;
        cycle();
        chk("s5_x0_busy", bus.rs1_busy, 64'(0));
        for (int k = 0; k < 3; k++) begin
            bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
            cycle();
        end
        bus.iss_valid = 1'b0;
        #1;
        chk("s5_saturated", bus.iss_ready, 64'(0));
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h3333;
        cycle();
        idle();
        cycle();
        chk("s5_wb_x3", bus.wb_rd, 64'(3));
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        cycle();
        bus.iss_valid = 1'b0;
        #1;
        chk("s5_inc_dec_hold", bus.iss_ready, 64'(0));

        // Reset with loads buffered and counters non-zero.
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle();
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd21;
            bus.ld_valid = 1'b1; bus.ld_rd = reg_idx_t'(6 + k); bus.ld_data = xword_t'(32'h600 + k);
            cycle();
        end
        idle();
        bus.q_rs1 = 5'd6; bus.q_rs2 = 5'd3; bus.q_rd = 5'd6;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("s6_wb_en", bus.wb_en, 64'(0));
        chk("s6_ld_ready", bus.ld_ready, 64'(1));
        chk("s6_rs1_busy", bus.rs1_busy, 64'(0));
        chk("s6_rs2_busy", bus.rs2_busy, 64'(0));
        chk("s6_rd_busy", bus.rd_busy, 64'(0));
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("s6_no_stale_wb", bus.wb_en, 64'(0));
        end

        // Random traffic; LSU holds a refused load, issues only when legal.
        m_acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reg_idx_t ir;
            bus.alu_valid = ($urandom_range(0, 9) < 4);
            bus.alu_rd    = reg_idx_t'($urandom_range(0, 31));
            bus.alu_data  = $urandom;
            ir = reg_idx_t'($urandom_range(0, 7));
            bus.iss_rd    = ir;
            bus.iss_valid = (mcnt[ir] < CMAX) && ($urandom_range(0, 2) == 0);
            if (!bus.ld_valid || m_acc) begin
                bus.ld_valid = ($urandom_range(0, 1) == 1);
                bus.ld_rd    = reg_idx_t'($urandom_range(0, 7));
                bus.ld_data  = $urandom;
            end
            bus.q_rs1 = reg_idx_t'($urandom_range(0, 7));
            bus.q_rs2 = reg_idx_t'($urandom_range(0, 7));
            bus.q_rd  = reg_idx_t'($urandom_range(0, 7));
            rst = ($urandom_range(0, 499) == 0);
            cycle();
            if (rst) bus.ld_valid = 1'b0;
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
